br_pred: RTL and testbench



---
 rtl/br_pkg.sv | 40 ++++
 rtl/br_cmp.sv | 27 ++
 rtl/br_pred.sv | 140 ++++++++++++++
 tb/tb_br_pred.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and constants for the branch resolution / prediction unit:
// compare encodings, 2-bit counter states and the BTB entry layout.
package br_pkg;

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LT  = 3'd4;
  localparam logic [2:0] BR_GE  = 3'd5;
  localparam logic [2:0] BR_LTU = 3'd6;
  localparam logic [2:0] BR_GEU = 3'd7;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Entry fields are sized for the widest supported PC (RV32); narrower
  // tags and targets are stored zero-extended.
  localparam int BR_XLEN_MAX = 32;

  typedef logic [1:0] ctr_t;

  typedef struct packed {
    logic                   valid;
    logic [BR_XLEN_MAX-1:0] tag;
    logic [BR_XLEN_MAX-1:0] target;
    ctr_t                   ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    if (c == CTR_ST) return CTR_ST;
    else             return c + 2'd1;
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    if (c == CTR_SNT) return CTR_SNT;
    else              return c - 2'd1;
  endfunction

endpackage

// File: rtl/br_cmp.sv
// Combinational XLEN-wide branch condition evaluator.
module br_cmp
  import br_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      comp_ctrl,
  output logic            cond
);

  // Select the comparison; encodings 2 and 3 never take the branch.
  always_comb begin
    cond = 1'b0;
    case (comp_ctrl)
      BR_EQ:   cond = (a == b);
      BR_NE:   cond = (a != b);
      BR_LT:   cond = ($signed(a) <  $signed(b));
      BR_GE:   cond = ($signed(a) >= $signed(b));
      BR_LTU:  cond = (a <  b);
      BR_GEU:  cond = (a >= b);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_pred.sv
// Branch resolution and direct-mapped BTB prediction with 2-bit counters.
// Optional performance counters are built when BR_PERF_EN is defined.
module br_pred
  import br_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int PC_LSB    = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      comp_ctrl,
  input  logic            do_branch,
  input  logic            do_jump,
  output logic            branch,
  output logic            jump,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     perf_br_cnt,
  output logic [31:0]     perf_miss_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = XLEN - PC_LSB - IDX_W;

  btb_entry_t             btb_r [BHT_DEPTH];
  btb_entry_t             if_entry_s, ex_entry_s, upd_entry_s;
  logic [IDX_W-1:0]       if_idx_s, ex_idx_s;
  logic [BR_XLEN_MAX-1:0] if_tag_s, ex_tag_s;
  logic                   if_hit_s, ex_hit_s;
  logic                   cond_s, qual_s, actual_s, mispredict_s, upd_we_s;
  logic                   unused_lsb_s;

  br_cmp #(.XLEN(XLEN)) u_cmp (
    .a         (a),
    .b         (b),
    .comp_ctrl (comp_ctrl),
    .cond      (cond_s)
  );

  assign unused_lsb_s = ^if_pc[PC_LSB-1:0];

  assign if_idx_s   = if_pc[PC_LSB +: IDX_W];
  assign ex_idx_s   = ex_pc[PC_LSB +: IDX_W];
  assign if_tag_s   = BR_XLEN_MAX'(if_pc[XLEN-1 -: TAG_W]);
  assign ex_tag_s   = BR_XLEN_MAX'(ex_pc[XLEN-1 -: TAG_W]);
  assign if_entry_s = btb_r[if_idx_s];
  assign ex_entry_s = btb_r[ex_idx_s];
  assign if_hit_s   = if_entry_s.valid & (if_entry_s.tag == if_tag_s);
  assign ex_hit_s   = ex_entry_s.valid & (ex_entry_s.tag == ex_tag_s);

  // Fetch-side prediction; target is forced to zero when not predicting taken.
  always_comb begin
    pred_taken = if_hit_s & if_entry_s.ctr[1];
    if (pred_taken) pred_target = if_entry_s.target[XLEN-1:0];
    else            pred_target = '0;
  end

  assign qual_s       = ex_valid & (do_branch | do_jump);
  assign branch       = cond_s & do_branch & ex_valid;
  assign jump         = do_jump;
  assign actual_s     = branch | (do_jump & ex_valid);
  assign mispredict_s = qual_s & ((actual_s != ex_pred_taken) |
                                  (actual_s & (ex_pred_target != ex_target)));
  assign redirect     = mispredict_s;
  assign redirect_pc  = actual_s ? ex_target : (ex_pc + XLEN'(32'd4));

  // Next contents of the EX-indexed entry; jumps take priority over branches.
  always_comb begin
    upd_we_s    = 1'b0;
    upd_entry_s = ex_entry_s;
    if (qual_s) begin
      if (ex_hit_s) begin
        upd_we_s = 1'b1;
        if (do_jump) begin
          upd_entry_s.ctr    = CTR_ST;
          upd_entry_s.target = BR_XLEN_MAX'(ex_target);
        end else if (actual_s) begin
          upd_entry_s.ctr    = ctr_inc(ex_entry_s.ctr);
          upd_entry_s.target = BR_XLEN_MAX'(ex_target);
        end else begin
          upd_entry_s.ctr    = ctr_dec(ex_entry_s.ctr);
        end
      end else if (actual_s) begin
        upd_we_s           = 1'b1;
        upd_entry_s.valid  = 1'b1;
        upd_entry_s.tag    = ex_tag_s;
        upd_entry_s.target = BR_XLEN_MAX'(ex_target);
        upd_entry_s.ctr    = do_jump ? CTR_ST : CTR_WT;
      end else begin
        upd_we_s = 1'b0;
      end
    end else begin
      upd_we_s = 1'b0;
    end
  end

  // Table storage; reset wins over a same-cycle update.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        btb_r[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (upd_we_s) begin
      btb_r[ex_idx_s] <= upd_entry_s;
    end
  end

`ifdef BR_PERF_EN
  logic [31:0] perf_br_cnt_r, perf_miss_cnt_r;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_br_cnt_r   <= 32'd0;
      perf_miss_cnt_r <= 32'd0;
    end else begin
      if (qual_s)       perf_br_cnt_r   <= perf_br_cnt_r + 32'd1;
      if (mispredict_s) perf_miss_cnt_r <= perf_miss_cnt_r + 32'd1;
    end
  end

  assign perf_br_cnt   = perf_br_cnt_r;
  assign perf_miss_cnt = perf_miss_cnt_r;
`else
  assign perf_br_cnt   = 32'd0;
  assign perf_miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_br_pred.sv
// Directed self-checking bench for br_pred (default parameters).
module tb_br_pred;
  import br_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_target, ex_pred_target, a, b;
  logic        ex_pred_taken;
  logic [2:0]  comp_ctrl;
  logic        do_branch, do_jump;
  logic        branch, jump, redirect;
  logic [31:0] redirect_pc, perf_br_cnt, perf_miss_cnt;

  int errors = 0;
  int checks = 0;

  br_pred dut (
    .clk(clk), .rstn(rstn), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .a(a), .b(b), .comp_ctrl(comp_ctrl),
    .do_branch(do_branch), .do_jump(do_jump),
    .branch(branch), .jump(jump), .redirect(redirect), .redirect_pc(redirect_pc),
    .perf_br_cnt(perf_br_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic ex_idle();
    ex_valid = 1'b0; do_branch = 1'b0; do_jump = 1'b0;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    a = 32'h0; b = 32'h0; comp_ctrl = 3'd0; ex_pc = 32'h0; ex_target = 32'h0;
  endtask

  task automatic ex_set(input logic [31:0] pc, tgt, input logic pt,
                        input logic [31:0] ptgt, av, bv, input logic [2:0] op,
                        input logic br, jp);
    ex_valid = 1'b1; ex_pc = pc; ex_target = tgt; ex_pred_taken = pt;
    ex_pred_target = ptgt; a = av; b = bv; comp_ctrl = op; do_branch = br; do_jump = jp;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    ex_set(32'h100, 32'h180, 1'b0, 32'h0, 32'd5, 32'd5, BR_EQ, 1'b1, 1'b0);
    step();
    step();
    rstn = 1'b1;
    ex_idle();
    if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_pred_target: got %h want 0", pred_target); end
    checks++; if (branch !== 1'b0) begin errors++; $display("FAIL reset_branch: got %b want 0", branch); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", redirect); end
    checks++; if (perf_br_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf_br: got %0d want 0", perf_br_cnt); end
    checks++; if (perf_miss_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf_miss: got %0d want 0", perf_miss_cnt); end
  endtask

  task automatic test_train();
    ex_set(32'h100, 32'h180, 1'b0, 32'h0, 32'd5, 32'd5, BR_EQ, 1'b1, 1'b0);
    if_pc = 32'h100;
    #1;
    checks++; if (branch !== 1'b1) begin errors++; $display("FAIL train_branch: got %b want 1", branch); end
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL train_redirect: got %b want 1", redirect); end
    checks++; if (redirect_pc !== 32'h180) begin errors++; $display("FAIL train_redirect_pc: got %h want 180", redirect_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL train_prewrite: got %b want 0", pred_taken); end
    step();
    ex_idle();
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_pred_taken: got %b want 1", pred_taken); end
    checks++; if (pred_target !== 32'h180) begin errors++; $display("FAIL train_pred_target: got %h want 180", pred_target); end
  endtask

  task automatic test_mispredict();
    ex_set(32'h100, 32'h180, 1'b1, 32'h180, 32'd5, 32'd5, BR_EQ, 1'b1, 1'b0);
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL correct_pred_redirect: got %b want 0", redirect); end
    step();
    ex_set(32'h100, 32'h180, 1'b1, 32'h180, 32'd5, 32'd3, BR_LT, 1'b1, 1'b0);
    #1;
    checks++; if (branch !== 1'b0) begin errors++; $display("FAIL blt_branch: got %b want 0", branch); end
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL blt_redirect: got %b want 1", redirect); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL blt_redirect_pc: got %h want 104", redirect_pc); end
    step();
    ex_idle();
    if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL blt_still_taken: got %b want 1", pred_taken); end
`ifdef BR_PERF_EN
    checks++; if (perf_br_cnt !== 32'd3) begin errors++; $display("FAIL perf_br: got %0d want 3", perf_br_cnt); end
    checks++; if (perf_miss_cnt !== 32'd2) begin errors++; $display("FAIL perf_miss: got %0d want 2", perf_miss_cnt); end
`else
    checks++; if (perf_br_cnt !== 32'd0) begin errors++; $display("FAIL perf_br_off: got %0d want 0", perf_br_cnt); end
    checks++; if (perf_miss_cnt !== 32'd0) begin errors++; $display("FAIL perf_miss_off: got %0d want 0", perf_miss_cnt); end
`endif
  endtask

  task automatic test_counter_sat();
    // Counter at 0x100 starts at 10; walk it through both saturation points.
    logic        tk   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        pt   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] ptg  [8] = '{32'h180, 32'h0, 32'h0, 32'h0, 32'h0, 32'h184, 32'h180, 32'h180};
    logic        red  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        look [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      ex_set(32'h100, 32'h180, pt[i], ptg[i], 32'd5, tk[i] ? 32'd5 : 32'd3, BR_EQ, 1'b1, 1'b0);
      #1;
      checks++; if (redirect !== red[i]) begin errors++; $display("FAIL ctr_redirect[%0d]: got %b want %b", i, redirect, red[i]); end
      step();
      ex_idle();
      #1;
      checks++; if (pred_taken !== look[i]) begin errors++; $display("FAIL ctr_lookup[%0d]: got %b want %b", i, pred_taken, look[i]); end
    end
  endtask

  task automatic test_compare();
    logic [31:0] av   [3] = '{32'hFFFF_FFFF, 32'd7, 32'd1};
    logic [31:0] bv   [3] = '{32'd1, 32'd7, 32'hFFFF_FFFF};
    logic [7:0]  mask [3] = '{8'h92, 8'hA1, 8'h62};
    for (int v = 0; v < 3; v++) begin
      for (int op = 0; op < 8; op++) begin
        ex_set(32'h010, 32'h080, 1'b0, 32'h0, av[v], bv[v], 3'(op), 1'b1, 1'b0);
        #1;
        checks++; if (branch !== mask[v][op]) begin errors++; $display("FAIL cmp[%0d] op %0d: got %b want %b", v, op, branch, mask[v][op]); end
      end
    end
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL cmp_jump: got %b want 0", jump); end
    ex_set(32'h010, 32'h080, 1'b0, 32'h0, 32'd1, 32'd2, BR_NE, 1'b1, 1'b0);
    ex_valid = 1'b0;
    #1;
    checks++; if (branch !== 1'b0) begin errors++; $display("FAIL bubble_branch: got %b want 0", branch); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL bubble_redirect: got %b want 0", redirect); end
    ex_idle();
    step();
  endtask

  task automatic test_alias();
    if_pc = 32'h200;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_miss: got %b want 0", pred_taken); end
    ex_set(32'h200, 32'h400, 1'b0, 32'h0, 32'h0, 32'h0, BR_EQ, 1'b0, 1'b1);
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL jal_redirect: got %b want 1", redirect); end
    checks++; if (redirect_pc !== 32'h400) begin errors++; $display("FAIL jal_redirect_pc: got %h want 400", redirect_pc); end
    checks++; if (jump !== 1'b1) begin errors++; $display("FAIL jal_jump: got %b want 1", jump); end
    checks++; if (branch !== 1'b0) begin errors++; $display("FAIL jal_branch: got %b want 0", branch); end
    step();
    ex_idle();
    if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL evicted_miss: got %b want 0", pred_taken); end
    if_pc = 32'h200;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jal_pred_taken: got %b want 1", pred_taken); end
    checks++; if (pred_target !== 32'h400) begin errors++; $display("FAIL jal_pred_target: got %h want 400", pred_target); end
  endtask

  task automatic test_same_cycle();
    ex_set(32'h200, 32'h500, 1'b1, 32'h400, 32'h0, 32'h0, BR_EQ, 1'b0, 1'b1);
    if_pc = 32'h200;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL tgt_miss_redirect: got %b want 1", redirect); end
    checks++; if (pred_target !== 32'h400) begin errors++; $display("FAIL same_cycle_old: got %h want 400", pred_target); end
    step();
    ex_idle();
    #1;
    checks++; if (pred_target !== 32'h500) begin errors++; $display("FAIL same_cycle_new: got %h want 500", pred_target); end
  endtask

  task automatic test_no_update();
    ex_set(32'h100, 32'h700, 1'b0, 32'h0, 32'h0, 32'h0, BR_EQ, 1'b0, 1'b1);
    ex_valid = 1'b0;
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL bubble_jump_redirect: got %b want 0", redirect); end
    step();
    ex_set(32'h200, 32'h900, 1'b1, 32'h500, 32'h0, 32'h0, BR_EQ, 1'b0, 1'b0);
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL nonbranch_redirect: got %b want 0", redirect); end
    step();
    ex_idle();
    if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL bubble_no_alloc: got %b want 0", pred_taken); end
    if_pc = 32'h200;
    #1;
    checks++; if (pred_target !== 32'h500) begin errors++; $display("FAIL nonbranch_no_write: got %h want 500", pred_target); end
  endtask

  task automatic test_reset_priority();
    rstn = 1'b0;
    ex_set(32'h100, 32'h600, 1'b0, 32'h0, 32'h0, 32'h0, BR_EQ, 1'b0, 1'b1);
    step();
    rstn = 1'b1;
    ex_idle();
    if_pc = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_no_update: got %b want 0", pred_taken); end
    if_pc = 32'h200;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_cleared: got %b want 0", pred_taken); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL rst_target: got %h want 0", pred_target); end
    checks++; if (perf_br_cnt !== 32'h0) begin errors++; $display("FAIL rst_perf_br: got %0d want 0", perf_br_cnt); end
    checks++; if (perf_miss_cnt !== 32'h0) begin errors++; $display("FAIL rst_perf_miss: got %0d want 0", perf_miss_cnt); end
  endtask

  initial begin
    rstn  = 1'b0;
    if_pc = 32'h0;
    ex_idle();
    test_reset();
    test_train();
    test_mispredict();
    test_counter_sat();
    test_compare();
    test_alias();
    test_same_cycle();
    test_no_update();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
